ula_74181_sync: RTL and testbench
=================================

// Module: ula_74181_sync
// PURPOSE
//  4-bit ALU with 74181 function set: 16 logic (M=1) and 16 arithmetic (M=0) operations plus an A==B compare.
//  Combinational core with all outputs registered on clk (1-cycle latency).
//  Leaf datapath block; wider ALUs cascade instances through c_in/c_out.
// PARAMETERS
//  none (width fixed at 4 bits)
// PORTS
//  clk     in   1  clock, rising-edge active
//  rst     in   1  reset, asynchronous, active-high
//  a       in   4  operand A
//  b       in   4  operand B
//  s       in   4  function select S3..S0
//  m       in   1  mode: 1=logic, 0=arithmetic
//  c_in    in   1  carry in, active-high (1 = add one); ignored when m=1
//  f       out  4  registered result
//  a_eq_b  out  1  registered compare, 1 when a==b
//  c_out   out  1  registered carry out, active-high
// BEHAVIOUR
//  - rst=1 (async): f=4'b0000, a_eq_b=0, c_out=0, held while rst=1. First capture on the first rising clk after release.
//  - Each rising clk (rst=0): f/a_eq_b/c_out <= combinational result of current a,b,s,m,c_in. No handshake; a new op every cycle.
//  - Logic (m=1), by s: 0:~A 1:~(A|B) 2:~A&B 3:0000 4:~(A&B) 5:~B 6:A^B 7:A&~B
//    8:~A|B 9:~(A^B) A:B B:A&B C:1111 D:A|~B E:A|B F:A. c_out=0 in logic mode.
//  - Arithmetic (m=0): X = A | (B&S0) | (~B&S1); Y = (A&~B&S2) | (A&B&S3).
//    {c_out,f} = X + Y + c_in, 5-bit unsigned.
//    Yields, by s (c_in=0): 0:A 1:A|B 2:A|~B 3:-1 4:A+(A&~B) 5:(A|B)+(A&~B) 6:A-B-1 7:(A&~B)-1
//    8:A+(A&B) 9:A+B A:(A|~B)+(A&B) B:(A&B)-1 C:A+A D:(A|B)+A E:(A|~B)+A F:A-1.
//  - Wrap-around: f is the low 4 bits; overflow sets c_out only. Subtract forms give c_out=1 when no borrow.
//  - a_eq_b = (a==b), independent of m, s, c_in and f.
//  - Inputs changing between edges have no effect until the next edge. rst asserted mid-stream clears outputs immediately.
// CONFIGURATION
//  ULA_74181_PG_EN defined: adds two registered outputs (same latency, reset value 1):
//    p_n  out 1  active-low group propagate = ~&(X|Y)
//    g_n  out 1  active-low group generate  = ~(carry out of X+Y with c_in=0)
//    Values are computed in both modes from the arithmetic X/Y terms.
//  Not defined: p_n/g_n ports and logic are absent; all other behaviour is identical.
// TESTING
//  1. rst=1 during arbitrary inputs -> f=0000, a_eq_b=0, c_out=0 with no clk edge needed;
//     after release, first edge loads results.
//  2. m=0 s=1001 a=0101 b=0011: c_in=0 -> f=1000 c_out=0; c_in=1 -> f=1001 c_out=0; a=1111 b=0001 c_in=0 -> f=0000 c_out=1.
//  3. m=0 s=0110 a=0101 b=0011 c_in=1 -> f=0010 c_out=1; c_in=0 -> f=0001 c_out=1;
//     s=0011 c_in=0 -> f=1111 c_out=0; c_in=1 -> f=0000 c_out=1.
//  4. m=1 a=1111 b=0000 sweep s=0..F -> f=0000,0000,0000,0000,1111,1111,1111,1111,0000,0000,0000,0000,1111,1111,1111,1111;
//     c_out=0 for c_in=0 and c_in=1.
//  5. m=1 s=0000 a=b=i for i=0..15 -> a_eq_b=1; b=~i -> a_eq_b=0. Each result appears exactly one clk after the inputs.
//  6. With ULA_74181_PG_EN: m=0 s=1001 a=0101 b=1010 -> p_n=0 g_n=1; a=1000 b=1000 -> g_n=0.

Source files
------------

// File: rtl/ula_74181_sync.sv
// 4-bit 74181-style ALU with registered outputs (one clock of latency).
// Define ULA_74181_PG_EN to add registered group propagate/generate outputs p_n/g_n.
module ula_74181_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       a_eq_b,
    output logic       c_out
`ifdef ULA_74181_PG_EN
    ,
    output logic       p_n,
    output logic       g_n
`endif
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;
    logic [3:0] logic_f;

    logic [3:0] f_d, f_q;
    logic       eq_d, eq_q;
    logic       c_d, c_q;

    // 74181 arithmetic terms: per-bit propagate-like X and generate-like Y
    always_comb begin
        x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
    end

    always_comb begin
        logic_f = 4'b0000;
        unique case (s)
            4'h0: logic_f = ~a;
            4'h1: logic_f = ~(a | b);
            4'h2: logic_f = ~a & b;
            4'h3: logic_f = 4'b0000;
            4'h4: logic_f = ~(a & b);
            4'h5: logic_f = ~b;
            4'h6: logic_f = a ^ b;
            4'h7: logic_f = a & ~b;
            4'h8: logic_f = ~a | b;
            4'h9: logic_f = ~(a ^ b);
            4'hA: logic_f = b;
            4'hB: logic_f = a & b;
            4'hC: logic_f = 4'b1111;
            4'hD: logic_f = a | ~b;
            4'hE: logic_f = a | b;
            4'hF: logic_f = a;
        endcase
    end

    always_comb begin
        f_d  = m ? logic_f : sum[3:0];
        c_d  = m ? 1'b0 : sum[4];
        eq_d = (a == b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q  <= 4'b0000;
            eq_q <= 1'b0;
            c_q  <= 1'b0;
        end else begin
            f_q  <= f_d;
            eq_q <= eq_d;
            c_q  <= c_d;
        end
    end

    assign f      = f_q;
    assign a_eq_b = eq_q;
    assign c_out  = c_q;

`ifdef ULA_74181_PG_EN
    logic [4:0] xy;
    logic       p_d, p_q;
    logic       g_d, g_q;

    // Group terms ignore c_in so they can feed an external lookahead unit
    always_comb begin
        xy  = {1'b0, x} + {1'b0, y};
        p_d = ~&(x | y);
        g_d = ~xy[4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= 1'b1;
            g_q <= 1'b1;
        end else begin
            p_q <= p_d;
            g_q <= g_d;
        end
    end

    assign p_n = p_q;
    assign g_n = g_q;
`endif

endmodule

// File: tb/tb_ula_74181_sync.sv
// Self-checking bench for ula_74181_sync: directed vectors plus random
// vectors checked against a formula-table reference model.
module tb_ula_74181_sync;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [3:0] f;
    logic       a_eq_b;
    logic       c_out;
`ifdef ULA_74181_PG_EN
    logic       p_n;
    logic       g_n;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] prev_f;
    logic       prev_c;
    logic       prev_eq;
    logic       prev_p;
    logic       prev_g;

    ula_74181_sync dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (f),
        .a_eq_b (a_eq_b),
        .c_out  (c_out)
`ifdef ULA_74181_PG_EN
        ,
        .p_n    (p_n),
        .g_n    (g_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the datasheet result table, with subtract forms biased by 16
    task automatic model(input logic [3:0] ta, input logic [3:0] tb,
                         input logic [3:0] ts, input logic tm,
                         input logic tc, output logic [3:0] ef,
                         output logic ec);
        int ia, ib, nb, v;
        bit sub;
        ia  = int'(ta);
        ib  = int'(tb);
        nb  = (~ib) & 15;
        sub = 0;
        v   = 0;
        if (tm) begin
            case (ts)
                4'h0: v = ~ia;
                4'h1: v = ~(ia | ib);
                4'h2: v = ~ia & ib;
                4'h3: v = 0;
                4'h4: v = ~(ia & ib);
                4'h5: v = ~ib;
                4'h6: v = ia ^ ib;
                4'h7: v = ia & nb;
                4'h8: v = ~ia | ib;
                4'h9: v = ~(ia ^ ib);
                4'hA: v = ib;
                4'hB: v = ia & ib;
                4'hC: v = 15;
                4'hD: v = ia | nb;
                4'hE: v = ia | ib;
                default: v = ia;
            endcase
            ef = 4'(v & 15);
            ec = 1'b0;
        end else begin
            case (ts)
                4'h0: v = ia;
                4'h1: v = ia | ib;
                4'h2: v = ia | nb;
                4'h3: begin v = -1; sub = 1; end
                4'h4: v = ia + (ia & nb);
                4'h5: v = (ia | ib) + (ia & nb);
                4'h6: begin v = ia - ib - 1; sub = 1; end
                4'h7: begin v = (ia & nb) - 1; sub = 1; end
                4'h8: v = ia + (ia & ib);
                4'h9: v = ia + ib;
                4'hA: v = (ia | nb) + (ia & ib);
                4'hB: begin v = (ia & ib) - 1; sub = 1; end
                4'hC: v = ia + ia;
                4'hD: v = (ia | ib) + ia;
                4'hE: v = (ia | nb) + ia;
                default: begin v = ia - 1; sub = 1; end
            endcase
            v = v + int'(tc);
            if (sub) v = v + 16;
            ef = 4'(v & 15);
            ec = ((v >> 4) & 1) != 0;
        end
    endtask

    task automatic pg_model(input logic [3:0] ta, input logic [3:0] tb,
                            input logic [3:0] ts, output logic ep,
                            output logic eg);
        int ia, ib, xi, yi;
        ia = int'(ta);
        ib = int'(tb);
        xi = 0;
        yi = 0;
        for (int i = 0; i < 4; i++) begin
            if (ta[i] || (tb[i] && ts[0]) || (!tb[i] && ts[1]))
                xi += (1 << i);
            if ((ta[i] && !tb[i] && ts[2]) || (ta[i] && tb[i] && ts[3]))
                yi += (1 << i);
        end
        ep = ((xi | yi) != 15);
        eg = (xi + yi) < 16;
        if (ia < 0 || ib < 0) ep = 1'b1;
    endtask

    // Drive one op, confirm outputs hold until the edge, then check the result
    task automatic step(input string tag, input logic [3:0] ta,
                        input logic [3:0] tb, input logic [3:0] ts,
                        input logic tm, input logic tc);
        logic [3:0] ef;
        logic ec, ep, eg;
        a    = ta;
        b    = tb;
        s    = ts;
        m    = tm;
        c_in = tc;
        model(ta, tb, ts, tm, tc, ef, ec);
        pg_model(ta, tb, ts, ep, eg);
        #1;
        check({tag, "_hold_f"}, {4'b0, f}, {4'b0, prev_f});
        check({tag, "_hold_eq"}, {7'b0, a_eq_b}, {7'b0, prev_eq});
        @(posedge clk);
        #1;
        check({tag, "_f"}, {4'b0, f}, {4'b0, ef});
        check({tag, "_c"}, {7'b0, c_out}, {7'b0, ec});
        check({tag, "_eq"}, {7'b0, a_eq_b}, {7'b0, (ta == tb)});
`ifdef ULA_74181_PG_EN
        check({tag, "_p"}, {7'b0, p_n}, {7'b0, ep});
        check({tag, "_g"}, {7'b0, g_n}, {7'b0, eg});
`endif
        prev_f  = ef;
        prev_c  = ec;
        prev_eq = (ta == tb);
        prev_p  = ep;
        prev_g  = eg;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_f"}, {4'b0, f}, 8'h00);
        check({tag, "_c"}, {7'b0, c_out}, 8'h00);
        check({tag, "_eq"}, {7'b0, a_eq_b}, 8'h00);
`ifdef ULA_74181_PG_EN
        check({tag, "_p"}, {7'b0, p_n}, 8'h01);
        check({tag, "_g"}, {7'b0, g_n}, 8'h01);
`endif
        prev_f  = 4'b0000;
        prev_c  = 1'b0;
        prev_eq = 1'b0;
        prev_p  = 1'b1;
        prev_g  = 1'b1;
    endtask

    logic [3:0] sweep [16];

    initial begin
        rst  = 1'b1;
        a    = 4'h7;
        b    = 4'h7;
        s    = 4'h9;
        m    = 1'b0;
        c_in = 1'b1;
        #2;
        check_reset("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check({"rst_first_f"}, {4'b0, f}, 8'h0f);
        check({"rst_first_eq"}, {7'b0, a_eq_b}, 8'h01);
        prev_f  = 4'hF;
        prev_c  = 1'b0;
        prev_eq = 1'b1;
        pg_model(4'h7, 4'h7, 4'h9, prev_p, prev_g);

        step("add0", 4'b0101, 4'b0011, 4'b1001, 1'b0, 1'b0);
        check("add0_lit", {4'b0, f}, 8'h08);
        step("add1", 4'b0101, 4'b0011, 4'b1001, 1'b0, 1'b1);
        check("add1_lit", {4'b0, f}, 8'h09);
        step("addov", 4'b1111, 4'b0001, 4'b1001, 1'b0, 1'b0);
        check("addov_lit", {3'b0, c_out, f}, 8'h10);
        step("sub1", 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b1);
        check("sub1_lit", {3'b0, c_out, f}, 8'h12);
        step("sub0", 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0);
        check("sub0_lit", {3'b0, c_out, f}, 8'h11);
        step("m1c0", 4'b0101, 4'b0011, 4'b0011, 1'b0, 1'b0);
        check("m1c0_lit", {3'b0, c_out, f}, 8'h0f);
        step("m1c1", 4'b0101, 4'b0011, 4'b0011, 1'b0, 1'b1);
        check("m1c1_lit", {3'b0, c_out, f}, 8'h10);

        sweep = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
        for (int i = 0; i < 32; i++) begin
            step("logic", 4'hF, 4'h0, 4'(i % 16), 1'b1, 1'(i / 16));
            check("logic_lit", {3'b0, c_out, f}, {4'b0, sweep[i % 16]});
        end

        for (int i = 0; i < 16; i++) begin
            step("eq", 4'(i), 4'(i), 4'h0, 1'b1, 1'b0);
            step("neq", 4'(i), ~4'(i), 4'h0, 1'b1, 1'b0);
        end

        step("pg_p", 4'b0101, 4'b1010, 4'b1001, 1'b0, 1'b0);
        step("pg_g", 4'b1000, 4'b1000, 4'b1001, 1'b0, 1'b0);
`ifdef ULA_74181_PG_EN
        check("pg_p_lit", {7'b0, g_n}, 8'h00);
`endif

        // Mid-stream reset clears outputs without waiting for an edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        @(posedge clk);
        #1;
        check_reset("rst_mid_held");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step("rnd", 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "bench timeout");
    end

endmodule
